// File: rtl/des_pkg.sv
// Shared widths, rotation schedule and FSM encoding for the DES key scheduler.
// Used by the scheduler top, its rotate helper and permutation_choice_two.
package des_pkg;

  localparam int KEY_CD_W = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  // Per-round left-rotation amount of DES encryption, indexed by round-1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [KEY_CD_W-1:0] rotl_cd(
    input logic [KEY_CD_W-1:0] cd,
    input logic                two
  );
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[KEY_CD_W-1:HALF_W];
    d = cd[HALF_W-1:0];
    if (two) begin
      c = {c[HALF_W-3:0], c[HALF_W-1:HALF_W-2]};
      d = {d[HALF_W-3:0], d[HALF_W-1:HALF_W-2]};
    end else begin
      c = {c[HALF_W-2:0], c[HALF_W-1]};
      d = {d[HALF_W-2:0], d[HALF_W-1]};
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_cd_rotate_right.sv
// Right-rotates the C and D halves of a DES key state by 1 or 2.
// amt = 0 rotates by one position, amt = 1 by two.
module des_cd_rotate_right
  import des_pkg::*;
(
  input  logic [KEY_CD_W-1:0] cd,
  input  logic                amt,
  output logic [KEY_CD_W-1:0] cd_rot
);

  logic [HALF_W-1:0] c;
  logic [HALF_W-1:0] d;
  logic [HALF_W-1:0] c1;
  logic [HALF_W-1:0] d1;
  logic [HALF_W-1:0] c2;
  logic [HALF_W-1:0] d2;

  assign c  = cd[KEY_CD_W-1:HALF_W];
  assign d  = cd[HALF_W-1:0];
  assign c1 = {c[0], c[HALF_W-1:1]};
  assign d1 = {d[0], d[HALF_W-1:1]};
  assign c2 = {c[1:0], c[HALF_W-1:2]};
  assign d2 = {d[1:0], d[HALF_W-1:2]};

  assign cd_rot = amt ? {c2, d2} : {c1, d1};

endmodule

// File: rtl/permutation_choice_two.sv
// DES PC2: selects and reorders 48 of the 56 C/D bits into a round subkey.
// Table entries are 1-based positions with bit 1 as the MSB of cd.
module permutation_choice_two
  import des_pkg::*;
(
  input  logic [KEY_CD_W-1:0] cd,
  output logic [SUBKEY_W-1:0] subkey
);

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // PC2 discards positions 9,18,22,25,35,38,43,54.
  logic unused_pc2_bits;
  assign unused_pc2_bits = ^{cd[47], cd[38], cd[34], cd[31],
                             cd[21], cd[18], cd[13], cd[2]};

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[6'(SUBKEY_W - 1 - i)] =
        cd[6'(KEY_CD_W - int'(PC2_TAB[i]))];
    end
  end

endmodule

// File: rtl/des_decrypt_key_scheduler.sv
// Streams DES subkeys K16..K1 from a post-PC1 key over valid/ready.
// Define DES_KEY_SCHED_ENC_MODE_EN to add enc_mode (K1..K16 order).
module des_decrypt_key_scheduler
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_CD_W-1:0] cd_in,
  input  logic                flush,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                subkey_last
`ifdef DES_KEY_SCHED_ENC_MODE_EN
  ,
  input  logic                enc_mode
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [KEY_CD_W-1:0] cd_q;
  logic [KEY_CD_W-1:0] cd_d;
  logic [KEY_CD_W-1:0] cd_rot;
  logic [3:0]          idx_q;
  logic [3:0]          idx_d;
  logic                rot_two;
  logic                is_last;

`ifdef DES_KEY_SCHED_ENC_MODE_EN
  logic       enc_q;
  logic       enc_d;
  logic [3:0] idx_inc;
  assign idx_inc = idx_q + 4'd1;
`else
  localparam logic enc_q = 1'b0;
`endif

  // Undo the rotation that produced the current subkey's C/D.
  assign rot_two = (SHIFT[idx_q] == 2'd2);

  des_cd_rotate_right u_rot (
    .cd     (cd_q),
    .amt    (rot_two),
    .cd_rot (cd_rot)
  );

  permutation_choice_two u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  assign is_last      = enc_q ? (idx_q == LAST_IDX)
                              : (idx_q == 4'd0);
  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = (state_q == RUN);
  assign subkey_last  = (state_q == RUN) && is_last;
  assign round_idx    = idx_q;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    idx_d   = idx_q;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
    enc_d   = enc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!flush && key_valid) begin
          state_d = RUN;
          cd_d    = cd_in;
          idx_d   = LAST_IDX;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
          enc_d   = enc_mode;
          if (enc_mode) begin
            cd_d  = rotl_cd(cd_in, SHIFT[0] == 2'd2);
            idx_d = 4'd0;
          end
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (subkey_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 4'd1;
            cd_d  = cd_rot;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
            if (enc_q) begin
              idx_d = idx_inc;
              cd_d  = rotl_cd(cd_q, SHIFT[idx_inc] == 2'd2);
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      idx_q   <= '0;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
`ifdef DES_KEY_SCHED_ENC_MODE_EN
      enc_q   <= enc_d;
`endif
    end
  end

endmodule
